// File: rtl/serial_tx_unit.sv
// Word serializer: loads a DATA_W word, sends it LANE_W bits per beat, CLK_DIV clocks per beat.
// Latency: first beat on the cycle after the start edge; no backpressure, StartTx is a level handshake held through DONE.
// Optional even-parity trailer beat when SERIAL_TX_PARITY_EN is defined.
module serial_tx_unit #(
    parameter int DATA_W  = 32,
    parameter int LANE_W  = 1,
    parameter int CLK_DIV = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              Sample,
    input  logic              StartTx,
    input  logic              MsbFirst,
    output logic [LANE_W-1:0] Dout,
    output logic              DoutValid,
    output logic              TxBusy,
    output logic              TxDone
);

    localparam int DATA_BEATS = DATA_W / LANE_W;
`ifdef SERIAL_TX_PARITY_EN
    localparam int BEATS = DATA_BEATS + 1;
`else
    localparam int BEATS = DATA_BEATS;
`endif
    localparam int CNT_W = $clog2(BEATS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [7:0]       DIV_LAST  = 8'(CLK_DIV - 1);

    if (DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
        $error("serial_tx_unit: DATA_W must be 8..64");
    end
    if (LANE_W < 1 || (DATA_W % LANE_W) != 0) begin : g_bad_lane_w
        $error("serial_tx_unit: LANE_W must divide DATA_W evenly");
    end
    if (CLK_DIV < 1 || CLK_DIV > 255) begin : g_bad_clk_div
        $error("serial_tx_unit: CLK_DIV must be 1..255");
    end

    logic [1:0]        state;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] shift_q;
    logic              dir_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic [7:0]        div_cnt;
    logic [LANE_W-1:0] dout_q;
    logic [CNT_W-1:0]  next_idx;
    logic [LANE_W-1:0] next_dout;

    // Beat k of a word in the chosen lane order.
    function automatic logic [LANE_W-1:0] data_beat(input logic [DATA_W-1:0] word,
                                                    input logic msb, input int k);
        if (msb)
            return LANE_W'(word >> (DATA_W - LANE_W - k * LANE_W));
        else
            return LANE_W'(word >> (k * LANE_W));
    endfunction

    always_comb begin
        next_idx  = beat_cnt + CNT_W'(1);
        next_dout = data_beat(shift_q, dir_q, int'(next_idx));
`ifdef SERIAL_TX_PARITY_EN
        if (int'(next_idx) == DATA_BEATS)
            next_dout = {LANE_W{^shift_q}};
`endif
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            hold_q   <= '0;
            shift_q  <= '0;
            dir_q    <= 1'b0;
            beat_cnt <= '0;
            div_cnt  <= '0;
            dout_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Sample)
                        hold_q <= DataIn;
                    // Shift register takes the pre-edge holding value even if Sample is also high.
                    if (StartTx) begin
                        shift_q  <= hold_q;
                        dir_q    <= MsbFirst;
                        beat_cnt <= '0;
                        div_cnt  <= '0;
                        dout_q   <= data_beat(hold_q, MsbFirst, 0);
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= S_DONE;
                        end else begin
                            beat_cnt <= next_idx;
                            dout_q   <= next_dout;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (Sample)
                        hold_q <= DataIn;
                    if (!StartTx)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Dout      = dout_q;
    assign DoutValid = (state == S_SHIFT);
    assign TxBusy    = (state == S_SHIFT);
    assign TxDone    = (state == S_DONE);

endmodule

// File: tb/tb_serial_tx_unit.sv
// Directed bench for serial_tx_unit: 1-bit, 8-bit/div-3 and 4-bit lane instances.
module tb_serial_tx_unit;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] a_data = '0, b_data = '0, c_data = '0;
    logic a_sample = 0, a_start = 0, a_msb = 0;
    logic b_sample = 0, b_start = 0, b_msb = 0;
    logic c_sample = 0, c_start = 0, c_msb = 0;
    logic [0:0] a_dout;
    logic [7:0] b_dout;
    logic [3:0] c_dout;
    logic a_vld, a_busy, a_done;
    logic b_vld, b_busy, b_done;
    logic c_vld, c_busy, c_done;

    serial_tx_unit #(.DATA_W(32), .LANE_W(1), .CLK_DIV(1)) ua (
        .Clk(Clk), .Reset(Reset), .DataIn(a_data), .Sample(a_sample), .StartTx(a_start),
        .MsbFirst(a_msb), .Dout(a_dout), .DoutValid(a_vld), .TxBusy(a_busy), .TxDone(a_done));
    serial_tx_unit #(.DATA_W(32), .LANE_W(8), .CLK_DIV(3)) ub (
        .Clk(Clk), .Reset(Reset), .DataIn(b_data), .Sample(b_sample), .StartTx(b_start),
        .MsbFirst(b_msb), .Dout(b_dout), .DoutValid(b_vld), .TxBusy(b_busy), .TxDone(b_done));
    serial_tx_unit #(.DATA_W(32), .LANE_W(4), .CLK_DIV(1)) uc (
        .Clk(Clk), .Reset(Reset), .DataIn(c_data), .Sample(c_sample), .StartTx(c_start),
        .MsbFirst(c_msb), .Dout(c_dout), .DoutValid(c_vld), .TxBusy(c_busy), .TxDone(c_done));

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Starts instance A, captures up to 32 data beats while busy (bounded).
    task automatic a_send(input logic msb, input logic hold, input logic poke,
                          output logic [31:0] w, output int cycles);
        a_msb   = msb;
        a_start = 1'b1;
        tick();
        a_sample = 1'b0;
        if (!hold) a_start = 1'b0;
        w = '0;
        cycles = 0;
        while (a_busy === 1'b1 && cycles < 40) begin
            if (cycles < 32) w = msb ? {w[30:0], a_dout[0]} : {a_dout[0], w[31:1]};
            if (poke && cycles == 5) begin
                a_data   = 32'hDEADBEEF;
                a_sample = 1'b1;
            end else begin
                a_sample = 1'b0;
            end
            cycles++;
            tick();
        end
        a_sample = 1'b0;
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        #1;
        n_checks++;
        if ({a_dout, a_vld, a_busy, a_done} !== 4'b0) begin
            n_fail++; $display("FAIL reset_a: got %b want 0000", {a_dout, a_vld, a_busy, a_done});
        end
        n_checks++;
        if ({b_dout, b_vld, b_busy, b_done} !== 11'b0) begin
            n_fail++; $display("FAIL reset_b: got %h want 000", {b_dout, b_vld, b_busy, b_done});
        end
        n_checks++;
        if ({c_dout, c_vld, c_busy, c_done} !== 7'b0) begin
            n_fail++; $display("FAIL reset_c: got %h want 00", {c_dout, c_vld, c_busy, c_done});
        end
        tick();
        Reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({a_busy, a_done, b_busy, c_busy} !== 4'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {a_busy, a_done, b_busy, c_busy});
        end
    endtask

    task automatic test_msb_word();
        logic exp;
        logic last;
        a_data   = 32'h80000001;
        a_sample = 1'b1;
        tick();
        a_sample = 1'b0;
        a_msb    = 1'b1;
        a_start  = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 32; k++) begin
            exp = (k == 0 || k == 31);
            n_checks++;
            if ({a_dout, a_vld, a_busy, a_done} !== {exp, 3'b110}) begin
                n_fail++;
                $display("FAIL msb_beat%0d: got %b want %b", k, {a_dout, a_vld, a_busy, a_done}, {exp, 3'b110});
            end
            tick();
        end
        if (PAR == 1) tick();
        last = (PAR == 1) ? 1'b0 : 1'b1;
        n_checks++;
        if ({a_dout, a_vld, a_busy, a_done} !== {last, 3'b001}) begin
            n_fail++;
            $display("FAIL msb_done: got %b want %b", {a_dout, a_vld, a_busy, a_done}, {last, 3'b001});
        end
        tick();
        n_checks++;
        if ({a_busy, a_done} !== 2'b00) begin
            n_fail++; $display("FAIL msb_idle: got %b want 00", {a_busy, a_done});
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int cyc;
        a_data   = 32'h12345678;
        a_sample = 1'b1;
        tick();
        a_data   = 32'h55AA55AA;
        a_sample = 1'b1;
        a_send(1'b1, 1'b0, 1'b1, w, cyc);
        n_checks++;
        if (w !== 32'h12345678) begin
            n_fail++; $display("FAIL b2b_first: got %h want 12345678", w);
        end
        n_checks++;
        if (cyc !== 32 + PAR) begin
            n_fail++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, 32 + PAR);
        end
        n_checks++;
        if (a_done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done: got %b want 1", a_done);
        end
        tick();
        a_send(1'b1, 1'b0, 1'b0, w, cyc);
        n_checks++;
        if (w !== 32'h55AA55AA) begin
            n_fail++; $display("FAIL b2b_second: got %h want 55aa55aa", w);
        end
        tick();
    endtask

    task automatic test_done_hold();
        logic [31:0] w;
        int cyc;
        a_data   = 32'h0F0F0F0F;
        a_sample = 1'b1;
        tick();
        a_send(1'b0, 1'b1, 1'b0, w, cyc);
        n_checks++;
        if (w !== 32'h0F0F0F0F) begin
            n_fail++; $display("FAIL hold_word: got %h want 0f0f0f0f", w);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({a_vld, a_busy, a_done} !== 3'b001) begin
                n_fail++; $display("FAIL hold_done%0d: got %b want 001", i, {a_vld, a_busy, a_done});
            end
            if (i < 4) tick();
        end
        a_start = 1'b0;
        tick();
        n_checks++;
        if ({a_busy, a_done} !== 2'b00) begin
            n_fail++; $display("FAIL hold_release: got %b want 00", {a_busy, a_done});
        end
    endtask

    task automatic test_lane8_div3();
        logic [7:0] tbl [0:4];
        tbl[0] = 8'hD4; tbl[1] = 8'hC3; tbl[2] = 8'hB2; tbl[3] = 8'hA1; tbl[4] = 8'hFF;
        b_data   = 32'hA1B2C3D4;
        b_sample = 1'b1;
        tick();
        b_sample = 1'b0;
        b_msb    = 1'b0;
        b_start  = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < (4 + PAR) * 3; i++) begin
            n_checks++;
            if ({b_dout, b_vld, b_busy, b_done} !== {tbl[i / 3], 3'b110}) begin
                n_fail++;
                $display("FAIL lane8_cyc%0d: got %h/%b want %h/110", i, b_dout, {b_vld, b_busy, b_done}, tbl[i / 3]);
            end
            tick();
        end
        n_checks++;
        if ({b_dout, b_vld, b_busy, b_done} !== {tbl[3 + PAR], 3'b001}) begin
            n_fail++;
            $display("FAIL lane8_done: got %h/%b want %h/001", b_dout, {b_vld, b_busy, b_done}, tbl[3 + PAR]);
        end
        tick();
    endtask

    task automatic test_lane4_parity();
        logic [3:0] exp;
        c_data   = 32'h00000007;
        c_sample = 1'b1;
        tick();
        c_sample = 1'b0;
        c_msb    = 1'b0;
        c_start  = 1'b1;
        tick();
        c_start = 1'b0;
        for (int k = 0; k < 8 + PAR; k++) begin
            exp = (k == 0) ? 4'h7 : (k == 8) ? 4'hF : 4'h0;
            n_checks++;
            if ({c_dout, c_vld, c_busy} !== {exp, 2'b11}) begin
                n_fail++; $display("FAIL lane4_beat%0d: got %h/%b want %h/11", k, c_dout, {c_vld, c_busy}, exp);
            end
            tick();
        end
        n_checks++;
        if ({c_busy, c_done} !== 2'b01) begin
            n_fail++; $display("FAIL lane4_done: got %b want 01", {c_busy, c_done});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        int cyc;
        a_data   = 32'hFFFFFFFF;
        a_sample = 1'b1;
        tick();
        a_sample = 1'b0;
        a_msb    = 1'b1;
        a_start  = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (10) tick();
        n_checks++;
        if ({a_dout, a_busy} !== 2'b11) begin
            n_fail++; $display("FAIL mid_beat10: got %b want 11", {a_dout, a_busy});
        end
        Reset = 1'b0;
        #1;
        n_checks++;
        if ({a_dout, a_vld, a_busy, a_done} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_reset: got %b want 0000", {a_dout, a_vld, a_busy, a_done});
        end
        tick();
        Reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({a_vld, a_busy, a_done} !== 3'b000) begin
            n_fail++; $display("FAIL mid_idle: got %b want 000", {a_vld, a_busy, a_done});
        end
        a_send(1'b1, 1'b0, 1'b0, w, cyc);
        n_checks++;
        if (w !== 32'h0 || cyc !== 32 + PAR) begin
            n_fail++; $display("FAIL mid_cleared_hold: got %h/%0d want 00000000/%0d", w, cyc, 32 + PAR);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_msb_word();
        test_back_to_back();
        test_done_hold();
        test_lane8_div3();
        test_lane4_parity();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_unit.md
SERIAL_TX_UNIT -- requirements
Module: serial_tx_unit

Interface
REQ-001 Parameter DATA_W, 32, word width in bits; SHALL be 8..64.
REQ-002 Parameter LANE_W, 1, bits per beat; SHALL divide DATA_W evenly (elaboration error otherwise).
REQ-003 Parameter CLK_DIV, 1, Clk cycles per beat; SHALL be 1..255.
REQ-004 Clk  input  1  sole clock; all state updates on posedge.
REQ-005 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 DataIn  input  DATA_W  word to transmit.
REQ-007 Sample  input  1  load DataIn into holding register.
REQ-008 StartTx  input  1  start request / done acknowledge level.
REQ-009 MsbFirst  input  1  1 = MSB lane first, 0 = LSB lane first; sampled at start.
REQ-010 Dout  output  LANE_W  current beat data.
REQ-011 DoutValid  output  1  Dout carries a valid beat.
REQ-012 TxBusy  output  1  transmission in progress.
REQ-013 TxDone  output  1  transmission finished, awaiting StartTx low.

Function
REQ-014 The block SHALL implement states IDLE, SHIFT, DONE.
REQ-015 Sample=1 in IDLE or DONE SHALL load DataIn into the holding register at the edge; Sample in SHIFT SHALL be ignored.
REQ-016 IDLE->SHIFT on an edge with StartTx=1: shift register <= holding register, direction latched from MsbFirst, beat counter <= 0, divider <= 0.
REQ-017 Sample and StartTx together in IDLE: shift register SHALL take the old holding value; holding register SHALL take DataIn.
REQ-018 In SHIFT, Dout SHALL present beat k for exactly CLK_DIV cycles, first beat visible the cycle after the start edge, DoutValid=1, TxBusy=1.
REQ-019 MSB-first beat k SHALL be word bits [DATA_W-1-k*LANE_W -: LANE_W]; LSB-first beat k SHALL be bits [k*LANE_W +: LANE_W].
REQ-020 Beat count SHALL be DATA_W/LANE_W (+1 with parity, REQ-029); total SHIFT duration = beats*CLK_DIV cycles.
REQ-021 StartTx deasserting during SHIFT SHALL NOT abort; transmission completes.
REQ-022 After the last beat's final cycle: SHIFT->DONE, TxBusy=0, DoutValid=0, TxDone=1, Dout holds last value.
REQ-023 DONE SHALL persist while StartTx=1; StartTx=0 at an edge SHALL go to IDLE and clear TxDone the next cycle.
REQ-024 A new start SHALL require passing through IDLE (StartTx held high never restarts).
REQ-025 Counters SHALL not wrap: beat counter width ceil(log2(beats+1)), divider width 8.

Reset
REQ-026 Reset=0 SHALL immediately force IDLE, Dout=0, DoutValid=0, TxBusy=0, TxDone=0, holding and shift registers=0, counters=0, regardless of state.
REQ-027 On Reset release the block SHALL stay in IDLE until StartTx=1 is sampled at a Clk edge.
REQ-028 Reset asserted mid-SHIFT SHALL abandon the word; no partial TxDone.

Configuration
REQ-029 With SERIAL_TX_PARITY_EN defined: one extra beat after data, Dout = LANE_W copies of even parity (XOR) of the transmitted word, DoutValid=1.
REQ-030 Without SERIAL_TX_PARITY_EN: no parity beat, no parity logic, beats = DATA_W/LANE_W exactly.

Verification
REQ-031 DATA_W=32, LANE_W=1, CLK_DIV=1, MsbFirst=1, Sample DataIn=0x80000001 then StartTx -> Dout 1,0x30,1 over 32 cycles, TxDone on cycle 33.
REQ-032 LANE_W=8, CLK_DIV=3, MsbFirst=0, word 0xA1B2C3D4 -> beats D4,C3,B2,A1 each 3 cycles, TxBusy high 12 cycles.
REQ-033 Same cycle Sample(0x55AA55AA) + StartTx with holding=0x12345678 -> 0x12345678 transmitted; next transmission sends 0x55AA55AA.
REQ-034 Reset=0 at beat 10 of a LANE_W=1 transfer -> all outputs 0 within the same cycle, IDLE after release, no TxDone.
REQ-035 StartTx held high after done for 5 cycles -> TxDone high 5 cycles, no restart; StartTx low -> TxDone 0 next cycle.
REQ-036 SERIAL_TX_PARITY_EN, LANE_W=4, word 0x00000007 -> 8 data beats then parity beat Dout=0xF.
